led_bit_decoder_mc: RTL

// - Multi-channel, parametrised WS2812-style serial decoder; next generation of the single-channel decode path.
// - Per channel: synchronise din, measure high-pulse width, classify as 0/1/error, detect treset low period.
// - Emits one shift_reg-style event per channel per decoded bit.
// - Sits between the board pins and the per-channel shift registers.

---
 rtl/led_bit_decoder_mc_pkg.sv | 27 ++
 rtl/led_bit_decoder_mc_ch.sv | 113 +++++++++++
 rtl/led_bit_decoder_mc.sv | 51 +++++
 3 files changed

// File: rtl/led_bit_decoder_mc_pkg.sv
// Shared types and default timing for the multi-channel LED bit decoder.
package led_bit_decoder_mc_pkg;

    // Default timing in clock cycles at 100 MHz.
    localparam int unsigned DEF_NUM_CH     = 4;
    localparam int unsigned DEF_CNT_W      = 13;
    localparam int unsigned DEF_HIGH_MIN   = 20;
    localparam int unsigned DEF_BIT_THRESH = 60;
    localparam int unsigned DEF_HIGH_MAX   = 120;
    localparam int unsigned DEF_TRESET_CYC = 5000;

    // One decode event per channel per cycle.
    typedef struct packed {
        logic decode_bit;
        logic valid_strobe;
        logic treset;
        logic error;
    } led_bit_event_t;

    localparam led_bit_event_t reset_values_led_event = '{
        decode_bit:   1'b0,
        valid_strobe: 1'b0,
        treset:       1'b0,
        error:        1'b0
    };

endpackage

// File: rtl/led_bit_decoder_mc_ch.sv
// Single-channel decode: synchroniser, high/low counters, two-stage classifier.
module led_bit_decoder_ch
    import led_bit_decoder_mc_pkg::*;
#(
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned HIGH_MIN   = DEF_HIGH_MIN,
    parameter int unsigned BIT_THRESH = DEF_BIT_THRESH,
    parameter int unsigned HIGH_MAX   = DEF_HIGH_MAX,
    parameter int unsigned TRESET_CYC = DEF_TRESET_CYC
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enable,
    input  logic           din,
    output led_bit_event_t evt
);

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] MIN_W      = CNT_W'(HIGH_MIN);
    localparam logic [CNT_W-1:0] THRESH_W   = CNT_W'(BIT_THRESH);
    localparam logic [CNT_W-1:0] MAX_W      = CNT_W'(HIGH_MAX);
    localparam logic [CNT_W-1:0] TRESET_W   = CNT_W'(TRESET_CYC);

    logic             sync_q1;
    logic             sync_q2;
    logic             prev_q;
    logic [2:0]       fill_q;
    logic             armed_q;
    logic             armed_d;
    logic [CNT_W-1:0] high_cnt_q;
    logic [CNT_W-1:0] high_cnt_d;
    logic [CNT_W-1:0] low_cnt_q;
    logic [CNT_W-1:0] low_cnt_d;
    logic             s1_vld_q;
    logic             s1_vld_d;
    logic [CNT_W-1:0] s1_width_q;
    logic [CNT_W-1:0] s1_width_d;
    led_bit_event_t   evt_d;
    logic             rise;
    logic             fall;
    logic             glitch;

    // Edge detect, counters, stage-1 capture and stage-2 classification.
    // fill_q keeps edges seen against post-reset flop contents from counting,
    // so a pulse already high at reset release never arms the channel.
    always_comb begin
        rise       = sync_q2 & ~prev_q & fill_q[2];
        fall       = ~sync_q2 & prev_q & fill_q[2];
        glitch     = (high_cnt_q < MIN_W);
        high_cnt_d = high_cnt_q;
        low_cnt_d  = low_cnt_q;
        armed_d    = armed_q | rise;
        s1_vld_d   = fall & armed_q;
        s1_width_d = s1_width_q;
        evt_d      = reset_values_led_event;

        if (rise) begin
            high_cnt_d = CNT_W'(1);
        end else if (sync_q2 && (high_cnt_q != CNT_MAX)) begin
            high_cnt_d = high_cnt_q + CNT_W'(1);
        end

        // A glitch leaves the low period running as if the pulse never happened.
        if (fall && !glitch) begin
            low_cnt_d = CNT_W'(1);
        end else if (!sync_q2 && (low_cnt_q != CNT_MAX)) begin
            low_cnt_d = low_cnt_q + CNT_W'(1);
        end

        if (s1_vld_d) begin
            s1_width_d = high_cnt_q;
        end

        evt_d.treset = (low_cnt_d == TRESET_W) && (low_cnt_q != TRESET_W);

        if (s1_vld_q) begin
            if (s1_width_q > MAX_W) begin
                evt_d.error = 1'b1;
            end else if (s1_width_q >= MIN_W) begin
                evt_d.valid_strobe = 1'b1;
                evt_d.decode_bit   = (s1_width_q >= THRESH_W);
            end
        end
    end

    // State and event registers; reset and disable both flush the channel.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            sync_q1    <= 1'b0;
            sync_q2    <= 1'b0;
            prev_q     <= 1'b0;
            fill_q     <= 3'b000;
            armed_q    <= 1'b0;
            high_cnt_q <= '0;
            low_cnt_q  <= '0;
            s1_vld_q   <= 1'b0;
            s1_width_q <= '0;
            evt        <= reset_values_led_event;
        end else begin
            sync_q1    <= din;
            sync_q2    <= sync_q1;
            prev_q     <= sync_q2;
            fill_q     <= {fill_q[1:0], 1'b1};
            armed_q    <= armed_d;
            high_cnt_q <= high_cnt_d;
            low_cnt_q  <= low_cnt_d;
            s1_vld_q   <= s1_vld_d;
            s1_width_q <= s1_width_d;
            evt        <= evt_d;
        end
    end

endmodule

// File: rtl/led_bit_decoder_mc.sv
// Multi-channel WS2812-style bit decoder: one independent decoder per input pin.
module led_bit_decoder_mc
    import led_bit_decoder_mc_pkg::*;
#(
    parameter int unsigned NUM_CH     = DEF_NUM_CH,
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned HIGH_MIN   = DEF_HIGH_MIN,
    parameter int unsigned BIT_THRESH = DEF_BIT_THRESH,
    parameter int unsigned HIGH_MAX   = DEF_HIGH_MAX,
    parameter int unsigned TRESET_CYC = DEF_TRESET_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [NUM_CH-1:0] din,
    output logic [NUM_CH-1:0] bit_o,
    output logic [NUM_CH-1:0] valid_o,
    output logic [NUM_CH-1:0] treset_o,
    output logic [NUM_CH-1:0] error_o
);

    // The low counter must be able to reach the treset threshold.
    if (((64'd1 << CNT_W) - 64'd1) < 64'(TRESET_CYC)) begin : g_cnt_w_check
        $error("CNT_W too narrow to count TRESET_CYC");
    end

    // One decoder per channel; events flattened onto the output vectors.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        led_bit_event_t evt;

        led_bit_decoder_ch #(
            .CNT_W      (CNT_W),
            .HIGH_MIN   (HIGH_MIN),
            .BIT_THRESH (BIT_THRESH),
            .HIGH_MAX   (HIGH_MAX),
            .TRESET_CYC (TRESET_CYC)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .enable (enable),
            .din    (din[i]),
            .evt    (evt)
        );

        assign bit_o[i]    = evt.decode_bit;
        assign valid_o[i]  = evt.valid_strobe;
        assign treset_o[i] = evt.treset;
        assign error_o[i]  = evt.error;
    end

endmodule
